// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetcher: streams words from the crossbar into a small
// FIFO so in-order CPU fetches complete with zero wait states; misses redirect it.
module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_address,
  input  logic        s_read,
  output logic [31:0] s_readdata,
  output logic        s_waitrequest,
  output logic [31:0] m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, FETCH} state_t;

  logic [29:0]   q_addr [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt, req_addr, s_aligned;
  logic [29:0]   next_addr;
  logic          discard, discard_nxt;
  logic          empty, hit, miss, flush, pop, done, push, hold;
  state_t        state, state_nxt;

  assign s_aligned = s_address & ~32'h3;
  assign empty     = (count == '0);
  assign hit       = !empty && (q_addr[rd_ptr] == s_aligned[31:2]);
  // Word that will land next in the queue; a discarded transfer doesn't count.
  assign next_addr = (state == FETCH && !discard) ? req_addr[31:2] : fetch_pc[31:2];
  assign miss      = s_read && !hit;
  assign flush     = miss && (!empty || next_addr != s_aligned[31:2]);
  assign pop       = s_read && hit;
  assign done      = (state == FETCH) && !m_waitrequest;
  assign push      = done && !discard && !flush;
  assign hold      = (state == FETCH) && m_waitrequest;

  assign s_waitrequest = miss;
  assign s_readdata    = empty ? 32'h0 : q_data[rd_ptr];
  assign m_read        = (state == FETCH);
  assign m_address     = m_read ? req_addr : fetch_pc;

  always_comb begin
    count_nxt    = count + CW'(push) - CW'(pop);
    fetch_pc_nxt = fetch_pc;
    discard_nxt  = discard;
    if (done) discard_nxt = 1'b0;
    if (push) fetch_pc_nxt = req_addr + 32'd4;
    if (flush) begin
      count_nxt    = '0;
      fetch_pc_nxt = s_aligned;
      // A transfer still stalled must complete, but its word is stale.
      discard_nxt  = hold;
    end
  end

  always_comb begin
    state_nxt = state;
    if (hold)                         state_nxt = FETCH;
    else if (count_nxt < CW'(DEPTH)) state_nxt = FETCH;
    else                              state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      discard  <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      fetch_pc <= fetch_pc_nxt;
      discard  <= discard_nxt;
      if (state_nxt == FETCH && !hold) req_addr <= fetch_pc_nxt;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage needs no reset: contents are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= req_addr[31:2];
      q_data[wr_ptr] <= m_readdata;
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: fill, hit stream, redirects, stalled
// transfers, reset mid-fetch and address wrap against a word-indexed memory.
module tb_fetch_prefetch_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] s_address = '0;
  logic        s_read = 1'b0;
  logic [31:0] s_readdata;
  logic        s_waitrequest;
  logic [31:0] m_address;
  logic        m_read;
  logic [31:0] m_readdata;
  logic        m_waitrequest;

  int checks = 0;
  int failures = 0;
  int stall_n = 0;
  int wait_cnt;
  int hold_err;
  logic        prev_hold;
  logic [31:0] prev_addr;
  logic [31:0] done_addr [$];

  always #5 clk = ~clk;

  fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .s_address(s_address), .s_read(s_read), .s_readdata(s_readdata),
    .s_waitrequest(s_waitrequest),
    .m_address(m_address), .m_read(m_read), .m_readdata(m_readdata),
    .m_waitrequest(m_waitrequest)
  );

  // Memory: word at byte address 4k holds 0x1000_0000 + k, stalls stall_n cycles.
  assign m_readdata    = 32'h1000_0000 + {2'b00, m_address[31:2]};
  assign m_waitrequest = m_read && (wait_cnt < stall_n);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= 0;
      prev_hold <= 1'b0;
      prev_addr <= '0;
      hold_err  <= 0;
    end else begin
      wait_cnt  <= (m_read && m_waitrequest) ? wait_cnt + 1 : 0;
      prev_hold <= m_read && m_waitrequest;
      prev_addr <= m_address;
      if (prev_hold && (!m_read || m_address != prev_addr)) hold_err <= hold_err + 1;
    end
  end

  always @(posedge clk) if (m_read && !m_waitrequest) done_addr.push_back(m_address);

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic        exp_wait;
    logic        chk_data;
    logic [31:0] exp_data;
    logic        exp_mread;
    logic [31:0] exp_maddr;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic rd, input logic [31:0] a);
    @(negedge clk);
    s_read = rd;
    s_address = a;
    #1;
  endtask

  task automatic do_reset(input int stall);
    @(negedge clk);
    rst = 1'b0;
    s_read = 1'b0;
    stall_n = stall;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic rd_word(input logic [31:0] a, input logic [31:0] exp, input string name);
    logic got;
    got = 1'b0;
    cyc(1'b1, a);
    for (int i = 0; i < 60; i++) begin
      if (!s_waitrequest) begin got = 1'b1; break; end
      cyc(1'b1, a);
    end
    chk({name, "_done"}, {31'b0, got}, 32'd1);
    if (got) chk({name, "_data"}, s_readdata, exp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, n10;
    logic got;
    tbl[0] = '{1'b1, 32'h00, 1'b0, 1'b1, 32'h1000_0000, 1'b0, 32'h10};
    tbl[1] = '{1'b1, 32'h04, 1'b0, 1'b1, 32'h1000_0001, 1'b1, 32'h10};
    tbl[2] = '{1'b1, 32'h08, 1'b0, 1'b1, 32'h1000_0002, 1'b1, 32'h14};
    tbl[3] = '{1'b1, 32'h0C, 1'b0, 1'b1, 32'h1000_0003, 1'b1, 32'h18};
    tbl[4] = '{1'b1, 32'h10, 1'b0, 1'b1, 32'h1000_0004, 1'b1, 32'h1C};
    tbl[5] = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h0,         1'b1, 32'h20};
    tbl[6] = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h0,         1'b0, 32'h24};
    tbl[7] = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h0,         1'b0, 32'h24};
    tbl[8] = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h0,         1'b1, 32'h40};
    tbl[9] = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h1000_0010, 1'b1, 32'h44};

    // Reset state
    s_read = 1'b1;
    #1;
    chk("rst_mread", {31'b0, m_read}, 32'd0);
    chk("rst_maddr", m_address, 32'h0);
    chk("rst_swait", {31'b0, s_waitrequest}, 32'd1);
    chk("rst_sdata", s_readdata, 32'h0);
    s_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Fill: four back-to-back fetches then stop
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 32'h0);
      chk($sformatf("fill_mread%0d", k), {31'b0, m_read}, 32'd1);
      chk($sformatf("fill_maddr%0d", k), m_address, 32'(4 * k));
    end
    cyc(1'b0, 32'h0);
    chk("fill_full_mread", {31'b0, m_read}, 32'd0);

    // Sequential hits, refill, redirect to 0x40
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].rd, tbl[i].addr);
      chk($sformatf("vec%0d_swait", i), {31'b0, s_waitrequest}, {31'b0, tbl[i].exp_wait});
      if (tbl[i].chk_data) chk($sformatf("vec%0d_sdata", i), s_readdata, tbl[i].exp_data);
      chk($sformatf("vec%0d_mread", i), {31'b0, m_read}, {31'b0, tbl[i].exp_mread});
      chk($sformatf("vec%0d_maddr", i), m_address, tbl[i].exp_maddr);
    end

    // Redirect to 0x80 while fetch of 0x10 is stalled
    do_reset(0);
    repeat (5) cyc(1'b0, 32'h0);
    stall_n = 3;
    cyc(1'b1, 32'h0);
    chk("redir_pop_data", s_readdata, 32'h1000_0000);
    base = done_addr.size();
    cyc(1'b1, 32'h80);
    chk("redir_mread", {31'b0, m_read}, 32'd1);
    chk("redir_maddr", m_address, 32'h10);
    chk("redir_swait", {31'b0, s_waitrequest}, 32'd1);
    n10 = 1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 32'h80);
      if (m_read && m_address == 32'h10) n10++;
      if (!s_waitrequest) begin got = 1'b1; break; end
    end
    chk("redir_done", {31'b0, got}, 32'd1);
    chk("redir_data", s_readdata, 32'h1000_0020);
    chk("redir_hold_cycles", 32'(n10), 32'd4);
    chk("redir_log_n", {31'b0, done_addr.size() >= base + 2}, 32'd1);
    if (done_addr.size() >= base + 2) begin
      chk("redir_first", done_addr[base], 32'h10);
      chk("redir_next", done_addr[base + 1], 32'h80);
    end
    cyc(1'b0, 32'h0);

    // Slow memory, sequential stream
    do_reset(5);
    for (int k = 0; k < 10; k++)
      rd_word(32'(4 * k), 32'h1000_0000 + 32'(k), $sformatf("slow%0d", k));

    // Reset while a fetch is outstanding
    cyc(1'b0, 32'h0);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_read) begin got = 1'b1; break; end
      cyc(1'b0, 32'h0);
    end
    chk("rstmid_in_fetch", {31'b0, got}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid_mread", {31'b0, m_read}, 32'd0);
    chk("rstmid_maddr", m_address, 32'h0);
    s_read = 1'b1;
    s_address = 32'h0;
    #1;
    chk("rstmid_empty_wait", {31'b0, s_waitrequest}, 32'd1);
    chk("rstmid_empty_data", s_readdata, 32'h0);
    s_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    base = done_addr.size();
    rd_word(32'h0, 32'h1000_0000, "rstmid_first");
    chk("rstmid_log_n", {31'b0, done_addr.size() > base}, 32'd1);
    if (done_addr.size() > base) chk("rstmid_first_addr", done_addr[base], 32'h0);

    // Address wrap and ignored low address bits
    stall_n = 0;
    rd_word(32'hFFFF_FFFC, 32'h4FFF_FFFF, "wrap_top");
    rd_word(32'h0000_0000, 32'h1000_0000, "wrap_zero");
    rd_word(32'h0000_0004, 32'h1000_0001, "wrap_four");
    rd_word(32'h0000_0009, 32'h1000_0002, "lowbits");
    cyc(1'b0, 32'h0);

    chk("hold_stable", 32'(hold_err), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
